// File: rtl/game_controller_if.sv
// rtl/game_controller_if.sv - player, countdown and display signals of the game controller
interface game_controller_if;
  logic       Start;
  logic       Mode;
  logic [3:0] Buttons;
  logic [7:0] TimeLeft;
  logic       TimerReset;
  logic       TimerSel;
  logic [3:0] Target;
  logic [7:0] Score;
  logic [7:0] Misses;
  logic       GameOver;
  logic [2:0] State;

  modport master (
    output Start, Mode, Buttons, TimeLeft,
    input  TimerReset, TimerSel, Target, Score, Misses, GameOver, State
  );

  modport slave (
    input  Start, Mode, Buttons, TimeLeft,
    output TimerReset, TimerSel, Target, Score, Misses, GameOver, State
  );
endinterface

// File: rtl/game_controller.sv
// rtl/game_controller.sv - whack-a-mole game FSM with LFSR target selection and scoring
module game_controller #(
  parameter int         MOLE_CYCLES = 25000000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic           ClockIn,
  input logic           Reset,
  game_controller_if.slave bus
);

  localparam int CW = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
  localparam logic [CW-1:0] MOLE_LOAD = CW'(MOLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SPAWN = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [3:0]    buttons_q;
  logic [3:0]    press_q;
  logic [CW-1:0] mole_cnt;
  logic [1:0]    prev_idx;
  logic          timer_reset;
  logic          timer_sel;
  logic [3:0]    target;
  logic [7:0]    score;
  logic [7:0]    misses;

  logic          lfsr_fb;
  logic [1:0]    raw_idx;
  logic [1:0]    spawn_idx;

  // Taps 7,5,4,3 realise x^8+x^6+x^5+x^4+1; never repeat the previous target
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign raw_idx   = lfsr[1:0];
  assign spawn_idx = (raw_idx == prev_idx) ? raw_idx + 2'd1 : raw_idx;

  // Game FSM; registered outputs take the value of the state being entered
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      buttons_q   <= 4'b0000;
      press_q     <= 4'b0000;
      mole_cnt    <= '0;
      prev_idx    <= 2'd0;
      timer_reset <= 1'b1;
      timer_sel   <= 1'b0;
      target      <= 4'b0000;
      score       <= 8'd0;
      misses      <= 8'd0;
    end else begin
      lfsr      <= {lfsr[6:0], lfsr_fb};
      buttons_q <= bus.Buttons;
      press_q   <= bus.Buttons & ~buttons_q;
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            state       <= LOAD;
            timer_reset <= 1'b1;
            timer_sel   <= bus.Mode;
            score       <= 8'd0;
            misses      <= 8'd0;
          end
        end
        LOAD: begin
          state       <= SPAWN;
          timer_reset <= 1'b0;
        end
        SPAWN: begin
          target   <= 4'b0001 << spawn_idx;
          prev_idx <= spawn_idx;
          mole_cnt <= MOLE_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.TimeLeft == 8'd0) begin
            state  <= DONE;
            target <= 4'b0000;
          end else if (press_q == target) begin
            if (score != 8'hFF) score <= score + 8'd1;
            state <= SPAWN;
          end else if (press_q != 4'b0000) begin
            if (misses != 8'hFF) misses <= misses + 8'd1;
            if (mole_cnt != '0) mole_cnt <= mole_cnt - 1'b1;
          end else if (mole_cnt == '0) begin
            state <= SPAWN;
          end else begin
            mole_cnt <= mole_cnt - 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          timer_reset <= 1'b1;
          target      <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.TimerReset = timer_reset;
  assign bus.TimerSel   = timer_sel;
  assign bus.Target     = target;
  assign bus.Score      = score;
  assign bus.Misses     = misses;
  assign bus.GameOver   = (state == DONE);
  assign bus.State      = state;

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - self-checking bench for game_controller
module tb_game_controller;

  logic ClockIn = 1'b0;
  logic Reset   = 1'b1;
  game_controller_if bus();

  game_controller #(.MOLE_CYCLES(8), .LFSR_SEED(8'hA5)) dut (
    .ClockIn(ClockIn),
    .Reset  (Reset),
    .bus    (bus)
  );

  always #5 ClockIn = ~ClockIn;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ClockIn);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k = 0;
    while (int'(bus.State) != s && k < budget) begin
      step(1);
      k++;
    end
    chk(name, int'(bus.State), s);
  endtask

  // Reference model: game rules evaluated once per clock edge
  bit         m_valid = 0;
  int         m_state, m_cnt, m_prev, m_idx;
  logic [7:0] m_score, m_misses, m_lfsr;
  logic [3:0] m_target, m_bq, m_pend, m_use;
  logic       m_tr, m_tsel;

  always @(posedge ClockIn) begin
    if (Reset) begin
      m_state = 0; m_score = 0; m_misses = 0; m_target = 0; m_tsel = 0; m_tr = 1;
      m_lfsr = 8'hA5; m_bq = 0; m_pend = 0; m_cnt = 0; m_prev = 0;
      m_valid = 1;
    end else begin
      m_use  = m_pend;
      m_pend = bus.Buttons & ~m_bq;
      m_bq   = bus.Buttons;
      case (m_state)
        0, 5: if (bus.Start) begin
          m_state = 1; m_tr = 1; m_tsel = bus.Mode; m_score = 0; m_misses = 0;
        end
        1: begin m_state = 2; m_tr = 0; end
        2: begin
          m_idx = int'(m_lfsr) % 4;
          if (m_idx == m_prev) m_idx = (m_idx + 1) % 4;
          m_target = 4'(1 << m_idx);
          m_prev = m_idx;
          m_cnt = 8 - 1;
          m_state = 3;
        end
        3: begin
          if (bus.TimeLeft == 0) begin
            m_state = 5; m_target = 0;
          end else if (m_use == m_target) begin
            m_score = (m_score == 255) ? 8'd255 : m_score + 8'd1;
            m_state = 2;
          end else if (m_use != 0) begin
            m_misses = (m_misses == 255) ? 8'd255 : m_misses + 8'd1;
            if (m_cnt > 0) m_cnt--;
          end else if (m_cnt == 0) begin
            m_state = 2;
          end else begin
            m_cnt--;
          end
        end
        default: m_state = 0;
      endcase
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  // Every cycle, every output against the model
  always @(negedge ClockIn) begin
    if (m_valid) begin
      chk("model_state",      int'(bus.State),      m_state);
      chk("model_score",      int'(bus.Score),      int'(m_score));
      chk("model_misses",     int'(bus.Misses),     int'(m_misses));
      chk("model_target",     int'(bus.Target),     int'(m_target));
      chk("model_timerreset", int'(bus.TimerReset), int'(m_tr));
      chk("model_timersel",   int'(bus.TimerSel),   int'(m_tsel));
      chk("model_gameover",   int'(bus.GameOver),   int'(m_state == 5));
    end
  end

  typedef struct {
    logic       rst, start, mode;
    logic [3:0] btn;
    logic [7:0] tl;
    logic [2:0] st;
    logic       tr, tsel, go;
  } vec_t;

  function automatic vec_t mk(int rst, int start, int mode, int btn, int tl,
                              int st, int tr, int tsel, int go);
    vec_t v;
    v.rst = 1'(rst); v.start = 1'(start); v.mode = 1'(mode); v.btn = 4'(btn);
    v.tl = 8'(tl); v.st = 3'(st); v.tr = 1'(tr); v.tsel = 1'(tsel); v.go = 1'(go);
    return v;
  endfunction

  task automatic new_game(input logic mode);
    Reset = 1; step(1); Reset = 0;
    bus.Start = 1; bus.Mode = mode; step(1); bus.Start = 0;
    wait_state(3, 10, "new_game_wait");
  endtask

  task automatic hit();
    wait_state(3, 20, "hit_wait");
    bus.Buttons = bus.Target; step(1);
    bus.Buttons = 0;          step(1);
  endtask

  vec_t vecs[10];

  initial begin
    logic [3:0] t_saved;
    logic [3:0] wrong;
    logic       fresh;
    int         cnt;
    logic [7:0] s_before;

    bus.Start = 0; bus.Mode = 0; bus.Buttons = 0; bus.TimeLeft = 8'd30;
    vecs[0] = mk(1, 0, 0, 0, 30, 0, 1, 0, 0);
    vecs[1] = mk(0, 1, 1, 0, 30, 1, 1, 1, 0);
    vecs[2] = mk(0, 0, 0, 0, 30, 2, 0, 1, 0);
    vecs[3] = mk(0, 0, 0, 0, 30, 3, 0, 1, 0);
    vecs[4] = mk(0, 1, 0, 0, 30, 3, 0, 1, 0);
    vecs[5] = mk(0, 0, 0, 0,  0, 5, 0, 1, 1);
    vecs[6] = mk(0, 0, 0, 0, 30, 5, 0, 1, 1);
    vecs[7] = mk(0, 1, 0, 0, 30, 1, 1, 0, 0);
    vecs[8] = mk(0, 0, 1, 0, 30, 2, 0, 0, 0);
    vecs[9] = mk(0, 0, 0, 0, 30, 3, 0, 0, 0);

    step(1);
    for (int i = 0; i < 10; i++) begin
      Reset = vecs[i].rst; bus.Start = vecs[i].start; bus.Mode = vecs[i].mode;
      bus.Buttons = vecs[i].btn; bus.TimeLeft = vecs[i].tl;
      step(1);
      chk($sformatf("vec%0d_state", i), int'(bus.State), int'(vecs[i].st));
      chk($sformatf("vec%0d_timerreset", i), int'(bus.TimerReset), int'(vecs[i].tr));
      chk($sformatf("vec%0d_timersel", i), int'(bus.TimerSel), int'(vecs[i].tsel));
      chk($sformatf("vec%0d_gameover", i), int'(bus.GameOver), int'(vecs[i].go));
      if (vecs[i].st == 3'd3) chk($sformatf("vec%0d_onehot", i), int'($onehot(bus.Target)), 1);
    end

    // Randomised play against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      Reset = ($urandom_range(0, 299) == 0);
      bus.Start = ($urandom_range(0, 19) == 0);
      bus.Mode = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 2) bus.Buttons = 4'($urandom);
      else if (r < 4) bus.Buttons = bus.Target;
      else bus.Buttons = 0;
      bus.TimeLeft = ($urandom_range(0, 49) == 0) ? 8'd0 : 8'd30;
      step(1);
    end
    Reset = 0; bus.Start = 0; bus.Buttons = 0; bus.TimeLeft = 8'd30;

    // Hit on 4'b0100: two-cycle score latency, new target, hold ignored
    new_game(1);
    fresh = 1;
    for (int k = 0; k < 400; k++) begin
      if (bus.State == 3'd3 && fresh && bus.Target == 4'b0100) break;
      fresh = (bus.State == 3'd2);
      step(1);
    end
    chk("find_target_0100", int'(bus.Target), 4);
    bus.Buttons = 4'b0100; step(1);
    chk("hit_score_latency", int'(bus.Score), 0);
    step(1);
    chk("hit_score", int'(bus.Score), 1);
    step(1);
    chk("hit_new_target_differs", int'(bus.Target != 4'b0100), 1);
    step(4);
    chk("hold_no_recount", int'(bus.Score), 1);
    bus.Buttons = 0; step(1);

    // Two misses, the second with two simultaneous edges
    new_game(0);
    t_saved = bus.Target;
    wrong = {t_saved[2:0], t_saved[3]};
    bus.Buttons = wrong;   step(1);
    bus.Buttons = 0;       step(1);
    bus.Buttons = 4'b0011; step(1);
    bus.Buttons = 0;       step(1);
    chk("miss_count", int'(bus.Misses), 2);
    chk("miss_score", int'(bus.Score), 0);
    chk("miss_target_kept", int'(bus.Target), int'(t_saved));
    chk("miss_still_wait", int'(bus.State), 3);
    wait_state(2, 20, "miss_then_expire");
    chk("miss_count_after_expire", int'(bus.Misses), 2);

    // Timeout after exactly 8 WAIT cycles
    new_game(1);
    cnt = 0;
    while (bus.State == 3'd3 && cnt < 50) begin
      step(1);
      cnt++;
    end
    chk("timeout_wait_cycles", cnt, 8);
    chk("timeout_to_spawn", int'(bus.State), 2);
    chk("timeout_score", int'(bus.Score), 0);
    chk("timeout_misses", int'(bus.Misses), 0);

    // TimeLeft==0 beats a correct press taking effect in the same cycle
    new_game(1);
    hit();
    wait_state(3, 20, "done_wait");
    s_before = bus.Score;
    chk("done_pre_score", int'(s_before), 1);
    bus.Buttons = bus.Target; step(1);
    bus.TimeLeft = 8'd0;      step(1);
    chk("done_state", int'(bus.State), 5);
    chk("done_score", int'(bus.Score), 1);
    chk("done_gameover", int'(bus.GameOver), 1);
    chk("done_target", int'(bus.Target), 0);
    bus.Buttons = 0; bus.TimeLeft = 8'd30; step(1);
    chk("done_holds", int'(bus.State), 5);
    bus.Start = 1; step(1); bus.Start = 0;
    chk("restart_load", int'(bus.State), 1);
    chk("restart_score", int'(bus.Score), 0);
    chk("restart_timerreset", int'(bus.TimerReset), 1);

    // Score saturation and mid-game reset
    new_game(0);
    repeat (260) hit();
    chk("score_saturated", int'(bus.Score), 255);
    wait_state(3, 20, "sat_wait");
    Reset = 1; step(1); Reset = 0;
    chk("reset_state", int'(bus.State), 0);
    chk("reset_score", int'(bus.Score), 0);
    chk("reset_timerreset", int'(bus.TimerReset), 1);
    chk("reset_target", int'(bus.Target), 0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter MOLE_CYCLES, default 25000000, meaning the clock cycles a lit target stays up before it respawns.
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the nonzero reset value of the target-selection LFSR.
REQ-003 ClockIn  in  1  single system clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  level, synchronous; starts or restarts a game.
REQ-006 Mode  in  1  game length select: 1 = 60 s, 0 = 30 s.
REQ-007 Buttons  in  4  synchronous, debounced player buttons, active-high.
REQ-008 TimeLeft  in  8  remaining seconds from the countdown block.
REQ-009 TimerReset  out  1  reload request to the countdown; active-high.
REQ-010 TimerSel  out  1  registered game length sent to the countdown Timer input.
REQ-011 Target  out  4  one-hot lit target LED; 4'b0000 means no target lit.
REQ-012 Score  out  8  hit count.
REQ-013 Misses  out  8  wrong-press count.
REQ-014 GameOver  out  1  high while in DONE.
REQ-015 State  out  3  current FSM state encoding, for debug.

Function
REQ-016 FSM states SHALL use these encodings: IDLE=0, LOAD=1, SPAWN=2, WAIT=3, DONE=5; other codes SHALL go to IDLE on the next cycle.
REQ-017 IDLE: TimerReset=1, Target=0, and Score and Misses held; Start=1 SHALL move to LOAD.
REQ-018 LOAD (exactly one cycle) SHALL do the following:
- drive TimerReset=1;
- set TimerSel<=Mode;
- clear Score and Misses;
- go to SPAWN.
REQ-019 SPAWN (exactly one cycle) SHALL do the following:
- drive TimerReset=0;
- compute idx = LFSR[1:0];
- if idx equals the previous target index, use idx+1 mod 4;
- register Target <= one-hot(idx) and store idx as the previous index;
- load the mole counter with MOLE_CYCLES-1;
- go to WAIT.
REQ-020 The previous target index SHALL reset to 0 and SHALL NOT be cleared by LOAD.
REQ-021 The LFSR SHALL be 8 bits with polynomial x^8+x^6+x^5+x^4+1, advance every cycle in every state, and never reach all-zero.
REQ-022 Button press events SHALL be rising edges: press = Buttons & ~Buttons_q, where Buttons_q is Buttons registered one cycle; presses take effect with one cycle of latency.
REQ-023 In WAIT, events SHALL be evaluated in this priority order (first match wins):
1. TimeLeft==0: go to DONE with no scoring.
2. press == Target: Score +1, saturating at 255; go to SPAWN.
3. press nonzero and press != Target (this includes multiple simultaneous edges): Misses +1, saturating at 255; stay in WAIT; the mole counter continues.
4. mole counter == 0: go to SPAWN with no scoring.
5. Otherwise: decrement the mole counter.
REQ-024 DONE: Target=0, GameOver=1, TimerReset=0, and Score and Misses held; Start=1 SHALL go to LOAD.
REQ-025 Start SHALL be ignored in SPAWN and WAIT.
REQ-026 Outputs SHALL be registered, except GameOver and State, which are decoded from the state register.

Reset
REQ-027 On Reset=1 at a clock edge, the following SHALL apply, and Reset SHALL override every other input:
- state <= IDLE;
- Score <= 0, Misses <= 0;
- Target <= 0, TimerSel <= 0;
- LFSR <= LFSR_SEED, Buttons_q <= 0, mole counter <= 0, previous index <= 0.
REQ-028 Reset asserted mid-game SHALL abort the game, and the next cycle SHALL show IDLE outputs.

Verification (MOLE_CYCLES=8; countdown modelled by the bench)
REQ-029 Reset, then Start pulse with Mode=1 -> one LOAD cycle with TimerReset=1, TimerSel=1, then SPAWN, then WAIT with exactly one Target bit set.
REQ-030 In WAIT with Target=4'b0100, press Buttons=4'b0100 -> Score=1 two cycles after the edge, new Target differs from 4'b0100; holding the button produces no further count.
REQ-031 Press a wrong button, then press 4'b0011 at once -> Misses=2, Score unchanged, Target unchanged until the mole counter expires.
REQ-032 No press -> after 8 WAIT cycles FSM returns to SPAWN; Score=0 and Misses=0.
REQ-033 TimeLeft=0 in the same cycle as a correct press edge -> DONE, Score not incremented, GameOver=1, Target=0; a later Start re-enters LOAD and clears Score.
REQ-034 Force Score=255 and hit again -> Score stays 255; assert Reset mid-WAIT -> next cycle IDLE, Score=0, TimerReset=1.
